rally_ctrl: RTL and testbench

RALLY_CTRL -- requirements
Module: rally_ctrl

---
 rtl/rally_ctrl_pkg.sv | 30 +++
 rtl/rally_ctrl_if.sv | 28 ++
 rtl/rally_ctrl_btn_edge.sv | 25 ++
 rtl/rally_ctrl.sv | 167 ++++++++++++++++
 tb/tb_rally_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rally_ctrl_pkg.sv
// Shared definitions for the pong rally controller and the LED display stage.
//   NUM_POS / POS_A / POS_B : ball track geometry (0 is A's end, 5 is B's end)
//   rally_state_t           : rally FSM state encodings
//   player_t                : identifies a player (server / loser)
//   serve_pos()             : ball position a given player serves from
package pong_pkg;

    localparam int NUM_POS = 6;
    localparam logic [2:0] POS_A = 3'd0;
    localparam logic [2:0] POS_B = 3'(NUM_POS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_MOVE_R    = 3'd2,
        ST_MOVE_L    = 3'd3,
        ST_POINT     = 3'd4,
        ST_GAME_OVER = 3'd5
    } rally_state_t;

    typedef enum logic {
        PLAYER_A = 1'b0,
        PLAYER_B = 1'b1
    } player_t;

    function automatic logic [2:0] serve_pos(input player_t p);
        return (p == PLAYER_B) ? POS_B : POS_A;
    endfunction

endpackage

// File: rtl/rally_ctrl_if.sv
// Player/display bundle of the rally controller.
//   on, hitA, hitB           : game enable and paddle buttons (towards the controller)
//   state                    : ball position 0..5
//   lostA, lostB             : point/game lost indications
//   scoreA, scoreB           : points this game
//   game_over                : a player reached the winning score
// master = the side driving buttons/enable, slave = the controller.
interface rally_ctrl_if;
    logic       on;
    logic       hitA;
    logic       hitB;
    logic [2:0] state;
    logic       lostA;
    logic       lostB;
    logic [3:0] scoreA;
    logic [3:0] scoreB;
    logic       game_over;

    modport master (
        output on, hitA, hitB,
        input  state, lostA, lostB, scoreA, scoreB, game_over
    );

    modport slave (
        input  on, hitA, hitB,
        output state, lostA, lostB, scoreA, scoreB, game_over
    );
endinterface

// File: rtl/rally_ctrl_btn_edge.sv
// Rising-edge detector for one paddle button.
//   clk_one_sec : game tick clock
//   reset       : synchronous active-high reset (clears the button history)
//   hit         : button level, already synchronised
//   rise        : high on the tick where hit is high and was low on the previous tick
// The button history is registered; rise is consumed only by the FSM's
// next-state logic, so module outputs downstream stay registered.
module btn_edge (
    input  logic clk_one_sec,
    input  logic reset,
    input  logic hit,
    output logic rise
);
    logic prev_reg;

    always_ff @(posedge clk_one_sec) begin
        if (reset) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= hit;
        end
    end

    assign rise = hit & ~prev_reg;
endmodule

// File: rtl/rally_ctrl.sv
// Pong rally controller: serves, moves the ball along a 6-position track,
// judges returns/misses/early hits and keeps score until WIN_SCORE.
//   clk_one_sec : game tick clock (all logic on its rising edge)
//   reset       : synchronous active-high reset, overrides everything
//   bus         : rally_ctrl_if.slave -- on/hitA/hitB in; state, lostA, lostB,
//                 scoreA, scoreB, game_over out (all registered)
import pong_pkg::*;

module rally_ctrl #(
    parameter int WIN_SCORE  = 5,
    parameter int HOLD_TICKS = 3
) (
    input  logic         clk_one_sec,
    input  logic         reset,
    rally_ctrl_if.slave  bus
);
    // Index 0 is player A, index 1 is player B.
    logic [1:0] hit_vec;
    logic [1:0] ev_vec;

    assign hit_vec = {bus.hitB, bus.hitA};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        btn_edge u_btn (
            .clk_one_sec (clk_one_sec),
            .reset       (reset),
            .hit         (hit_vec[gi]),
            .rise        (ev_vec[gi])
        );
    end

    logic ev_a;
    logic ev_b;
    assign ev_a = ev_vec[0];
    assign ev_b = ev_vec[1];

    rally_state_t fsm_reg;
    player_t      server_reg;
    logic [2:0]   state_reg;
    logic         lost_a_reg;
    logic         lost_b_reg;
    logic [3:0]   score_a_reg;
    logic [3:0]   score_b_reg;
    logic         game_over_reg;
    logic [3:0]   hold_cnt_reg;

    // Point judgement. Only the receiver (player the ball travels toward)
    // is examined: a hit before the end is early, no hit at the end is a miss.
    logic lose_a;
    logic lose_b;

    always_comb begin
        lose_a = 1'b0;
        lose_b = 1'b0;
        case (fsm_reg)
            ST_MOVE_R: lose_b = (state_reg == POS_B) ? ~ev_b : ev_b;
            ST_MOVE_L: lose_a = (state_reg == POS_A) ? ~ev_a : ev_a;
            default: ;
        endcase
    end

    // Scores saturate at WIN_SCORE.
    logic [3:0] score_a_inc;
    logic [3:0] score_b_inc;
    logic       a_wins;
    logic       b_wins;

    assign score_a_inc = (score_a_reg == 4'(WIN_SCORE)) ? score_a_reg : score_a_reg + 4'd1;
    assign score_b_inc = (score_b_reg == 4'(WIN_SCORE)) ? score_b_reg : score_b_reg + 4'd1;
    assign a_wins      = (score_a_inc == 4'(WIN_SCORE));
    assign b_wins      = (score_b_inc == 4'(WIN_SCORE));

    always_ff @(posedge clk_one_sec) begin
        if (reset || !bus.on) begin
            fsm_reg       <= ST_IDLE;
            server_reg    <= PLAYER_A;
            state_reg     <= POS_A;
            lost_a_reg    <= 1'b0;
            lost_b_reg    <= 1'b0;
            score_a_reg   <= 4'd0;
            score_b_reg   <= 4'd0;
            game_over_reg <= 1'b0;
            hold_cnt_reg  <= 4'd0;
        end else begin
            case (fsm_reg)
                ST_IDLE: begin
                    fsm_reg   <= ST_SERVE;
                    state_reg <= serve_pos(server_reg);
                end

                ST_SERVE: begin
                    if (server_reg == PLAYER_A && ev_a) begin
                        fsm_reg   <= ST_MOVE_R;
                        state_reg <= POS_A + 3'd1;
                    end else if (server_reg == PLAYER_B && ev_b) begin
                        fsm_reg   <= ST_MOVE_L;
                        state_reg <= POS_B - 3'd1;
                    end
                end

                ST_MOVE_R: begin
                    if (lose_b) begin
                        score_a_reg  <= score_a_inc;
                        lost_b_reg   <= 1'b1;
                        server_reg   <= PLAYER_B;
                        hold_cnt_reg <= 4'd0;
                        if (a_wins) begin
                            fsm_reg       <= ST_GAME_OVER;
                            game_over_reg <= 1'b1;
                        end else begin
                            fsm_reg <= ST_POINT;
                        end
                    end else if (state_reg == POS_B) begin
                        // Not losing at the end means B returned the ball.
                        fsm_reg   <= ST_MOVE_L;
                        state_reg <= POS_B - 3'd1;
                    end else begin
                        state_reg <= state_reg + 3'd1;
                    end
                end

                ST_MOVE_L: begin
                    if (lose_a) begin
                        score_b_reg  <= score_b_inc;
                        lost_a_reg   <= 1'b1;
                        server_reg   <= PLAYER_A;
                        hold_cnt_reg <= 4'd0;
                        if (b_wins) begin
                            fsm_reg       <= ST_GAME_OVER;
                            game_over_reg <= 1'b1;
                        end else begin
                            fsm_reg <= ST_POINT;
                        end
                    end else if (state_reg == POS_A) begin
                        fsm_reg   <= ST_MOVE_R;
                        state_reg <= POS_A + 3'd1;
                    end else begin
                        state_reg <= state_reg - 3'd1;
                    end
                end

                ST_POINT: begin
                    // The tick that entered POINT counts as the first held tick.
                    if (hold_cnt_reg == 4'(HOLD_TICKS - 1)) begin
                        fsm_reg    <= ST_SERVE;
                        lost_a_reg <= 1'b0;
                        lost_b_reg <= 1'b0;
                        state_reg  <= serve_pos(server_reg);
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 4'd1;
                    end
                end

                ST_GAME_OVER: ;

                default: fsm_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.state     = state_reg;
    assign bus.lostA     = lost_a_reg;
    assign bus.lostB     = lost_b_reg;
    assign bus.scoreA    = score_a_reg;
    assign bus.scoreB    = score_b_reg;
    assign bus.game_over = game_over_reg;
endmodule

// File: tb/tb_rally_ctrl.sv
// Self-checking bench for rally_ctrl: directed scenarios with literal
// expectations followed by randomized play, all compared every tick against
// a direction-generic behavioural model of the game.
module tb_rally_ctrl;
    localparam int WIN  = 5;
    localparam int HOLD = 3;

    localparam int PH_IDLE  = 0;
    localparam int PH_SERVE = 1;
    localparam int PH_RALLY = 2;
    localparam int PH_POINT = 3;
    localparam int PH_OVER  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rally_ctrl_if bus ();

    rally_ctrl #(.WIN_SCORE(WIN), .HOLD_TICKS(HOLD)) dut (
        .clk_one_sec (clk),
        .reset       (reset),
        .bus         (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    // Behavioural model: ball position plus a direction of travel (+1/-1).
    int m_phase = PH_IDLE;
    int m_pos = 0;
    int m_dir = 0;
    int m_server = 0;   // 0 = A, 1 = B
    int m_lost_a = 0;
    int m_lost_b = 0;
    int m_score_a = 0;
    int m_score_b = 0;
    int m_over = 0;
    int m_hold = 0;
    int m_prev_a = 0;
    int m_prev_b = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_lose(input int loser);
        if (loser == 1) begin
            m_score_a++;
            m_lost_b = 1;
        end else begin
            m_score_b++;
            m_lost_a = 1;
        end
        m_server = loser;
        if (m_score_a == WIN || m_score_b == WIN) begin
            m_over  = 1;
            m_phase = PH_OVER;
        end else begin
            m_phase = PH_POINT;
            m_hold  = 0;
        end
    endtask

    task automatic model_step(input int r, input int o, input int a, input int b);
        int ev_a, ev_b, recv_ev, at_end;
        ev_a = a & ~m_prev_a & 1;
        ev_b = b & ~m_prev_b & 1;
        m_prev_a = r ? 0 : a;
        m_prev_b = r ? 0 : b;
        if (r != 0 || o == 0) begin
            m_phase = PH_IDLE; m_pos = 0; m_dir = 0; m_server = 0;
            m_lost_a = 0; m_lost_b = 0; m_score_a = 0; m_score_b = 0;
            m_over = 0; m_hold = 0;
            return;
        end
        case (m_phase)
            PH_IDLE: begin
                m_phase = PH_SERVE;
                m_pos   = (m_server == 1) ? 5 : 0;
            end
            PH_SERVE: begin
                if ((m_server == 0 && ev_a != 0) || (m_server == 1 && ev_b != 0)) begin
                    m_dir   = (m_server == 0) ? 1 : -1;
                    m_pos   = m_pos + m_dir;
                    m_phase = PH_RALLY;
                end
            end
            PH_RALLY: begin
                recv_ev = (m_dir > 0) ? ev_b : ev_a;
                at_end  = (m_pos == ((m_dir > 0) ? 5 : 0)) ? 1 : 0;
                if (at_end != 0 && recv_ev != 0) begin
                    m_dir = -m_dir;
                    m_pos = m_pos + m_dir;
                end else if (at_end != 0 || recv_ev != 0) begin
                    model_lose((m_dir > 0) ? 1 : 0);
                end else begin
                    m_pos = m_pos + m_dir;
                end
            end
            PH_POINT: begin
                m_hold++;
                if (m_hold == HOLD) begin
                    m_phase  = PH_SERVE;
                    m_lost_a = 0;
                    m_lost_b = 0;
                    m_pos    = (m_server == 1) ? 5 : 0;
                end
            end
            default: ;
        endcase
    endtask

    // Drive one tick of inputs, advance the model, and return shortly after
    // the edge so directed checks can look at the registered outputs.
    task automatic step(input int r, input int o, input int a, input int b);
        reset    = (r != 0);
        bus.on   = (o != 0);
        bus.hitA = (a != 0);
        bus.hitB = (b != 0);
        model_step(r, o, a, b);
        @(posedge clk);
        #3;
    endtask

    // Per-tick comparison against the model.
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("state",     int'(bus.state),     m_pos);
            chk("lostA",     int'(bus.lostA),     m_lost_a);
            chk("lostB",     int'(bus.lostB),     m_lost_b);
            chk("scoreA",    int'(bus.scoreA),    m_score_a);
            chk("scoreB",    int'(bus.scoreB),    m_score_b);
            chk("game_over", int'(bus.game_over), m_over);
            chk("lost_excl", int'(bus.lostA & bus.lostB), 0);
        end
    end

    initial begin
        int seq_exp[12];
        int lost_cnt;
        int a, b, o, r;

        seq_exp = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
        reset = 1'b1; bus.on = 1'b0; bus.hitA = 1'b0; bus.hitB = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        step(1, 0, 0, 0);
        step(1, 1, 1, 1);
        chk("rst_state",  int'(bus.state), 0);
        chk("rst_scoreA", int'(bus.scoreA), 0);
        chk("rst_lostB",  int'(bus.lostB), 0);
        chk("rst_over",   int'(bus.game_over), 0);

        // Full rally: A serves, B returns at 5, A returns at 0
        step(0, 1, 0, 0); chk("rally_0", int'(bus.state), seq_exp[0]);
        step(0, 1, 1, 0); chk("rally_1", int'(bus.state), seq_exp[1]);
        for (int i = 2; i <= 5; i++) begin
            step(0, 1, 0, 0); chk($sformatf("rally_%0d", i), int'(bus.state), seq_exp[i]);
        end
        step(0, 1, 0, 1); chk("rally_6", int'(bus.state), seq_exp[6]);
        for (int i = 7; i <= 10; i++) begin
            step(0, 1, 0, 0); chk($sformatf("rally_%0d", i), int'(bus.state), seq_exp[i]);
        end
        step(0, 1, 1, 0); chk("rally_11", int'(bus.state), seq_exp[11]);
        chk("rally_nolost", int'(bus.lostA | bus.lostB), 0);

        // Miss at B's end, point hold, B serves
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        chk("miss_at5", int'(bus.state), 5);
        step(0, 1, 0, 0);
        chk("miss_lostB", int'(bus.lostB), 1);
        chk("miss_scoreA", int'(bus.scoreA), 1);
        chk("miss_hold_pos", int'(bus.state), 5);
        lost_cnt = 1;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            lost_cnt += int'(bus.lostB);
        end
        chk("miss_hold_ticks", lost_cnt, 3);
        chk("miss_serveB_pos", int'(bus.state), 5);
        step(0, 1, 0, 0);
        chk("miss_serve_wait", int'(bus.state), 5);

        // Early hit at state 3
        step(0, 0, 0, 0);
        chk("off_scoreA", int'(bus.scoreA), 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("early_at3", int'(bus.state), 3);
        step(0, 1, 0, 1);
        chk("early_lostB", int'(bus.lostB), 1);
        chk("early_scoreA", int'(bus.scoreA), 1);
        chk("early_pos", int'(bus.state), 3);

        // Held button: one event only
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
        chk("held_scoreA", int'(bus.scoreA), 1);
        chk("held_lostB", int'(bus.lostB), 1);
        chk("held_pos", int'(bus.state), 2);
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        chk("held_no_serve", int'(bus.state), 5);
        chk("held_clear", int'(bus.lostB), 0);

        // Game end: A wins five points via B early hits
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        for (int p = 0; p < WIN - 1; p++) begin
            step(0, 1, 0, 1);
            for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
            step(0, 1, 1, 0);
            step(0, 1, 0, 1);
            for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        end
        chk("game_scoreA", int'(bus.scoreA), 5);
        chk("game_scoreB", int'(bus.scoreB), 0);
        chk("game_over", int'(bus.game_over), 1);
        chk("game_lostB", int'(bus.lostB), 1);
        step(0, 0, 0, 0);
        chk("game_clr_over", int'(bus.game_over), 0);
        chk("game_clr_score", int'(bus.scoreA), 0);
        chk("game_clr_lost", int'(bus.lostB), 0);

        // Reset mid-rally
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("mid_at3", int'(bus.state), 3);
        step(1, 1, 1, 1);
        chk("mid_rst_state", int'(bus.state), 0);
        chk("mid_rst_flags", int'(bus.lostA | bus.lostB), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        chk("mid_serve_pos", int'(bus.state), 0);

        // Randomized play
        for (int n = 0; n < 4000; n++) begin
            a = ($urandom_range(0, 5) == 0) ? 1 : 0;
            b = ($urandom_range(0, 5) == 0) ? 1 : 0;
            if (m_phase == PH_SERVE && $urandom_range(0, 2) == 0) begin
                if (m_server == 0) a = 1; else b = 1;
            end
            if (m_phase == PH_RALLY && m_pos == ((m_dir > 0) ? 5 : 0)
                && $urandom_range(0, 4) != 0) begin
                if (m_dir > 0) b = 1; else a = 1;
            end
            o = ($urandom_range(0, 199) == 0) ? 0 : 1;
            r = ($urandom_range(0, 299) == 0) ? 1 : 0;
            step(r, o, a, b);
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
